keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 matrix keypad: it is the far end of the keypad scan interface.
- Takes the column scan lines driven by the scanner and returns row lines as a real keypad would, including contact bounce on press and release.
- Key presses are requested through a command handshake, from a bench or an on-chip self-test.
- Used for hardware-in-the-loop testing of the scan/debounce/display path without a physical keypad.

Parameters:
- BOUNCE_CYCLES, 2000, length of the bounce window on press and on release, in clk cycles (0 = clean edges, no bounce state).
- BOUNCE_TOGGLE, 50, contact is re-randomised every BOUNCE_TOGGLE cycles inside a bounce window (must be ≥1).
- GAP_CYCLES, 1000, minimum open-contact time after release before the next command is accepted (0 allowed).
- LFSR_SEED, 16'hACE1, reset value of the bounce LFSR (must be nonzero).

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- columnas  in  4  column drive from scanner; active-low (0 = column selected)
- cmd_valid  in  1  press request valid
- cmd_key  in  4  key code: [3:2] = row index, [1:0] = column index
- cmd_hold  in  16  stable-closed duration in cycles (0 treated as 1)
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- busy  out  1  high in every state except IDLE
- filas  out  4  row lines to scanner; active-low, idle all 1s
- contact  out  1  current modelled contact state (1 = closed), for debug

Behaviour:
- Single clock domain; all outputs registered. Reset is asynchronous and active-low; it is applied by n_reset going low and released synchronously to clk.
- Reset values:
  - filas = 4'b1111, contact = 0, cmd_ready = 1, busy = 0
  - state = IDLE, lfsr = LFSR_SEED, counters = 0, latched key and hold = 0
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle from reset onward, independent of state.
- FSM states:
  - IDLE:
    - On accept, latch cmd_key and cmd_hold (0 → 1).
    - Go to BOUNCE_PRESS, or directly to HOLD if BOUNCE_CYCLES = 0.
    - cmd_valid without ready is ignored; it is never queued.
  - BOUNCE_PRESS:
    - Counter runs 0..BOUNCE_CYCLES-1.
    - Whenever count % BOUNCE_TOGGLE == 0, contact <= lfsr[0].
    - On the last count: contact <= 1, go to HOLD.
  - HOLD:
    - contact = 1 for exactly the latched hold count of cycles.
    - Then go to BOUNCE_RELEASE, or directly to GAP if BOUNCE_CYCLES = 0.
  - BOUNCE_RELEASE:
    - Same toggling rule as BOUNCE_PRESS.
    - On the last count: contact <= 0, go to GAP.
  - GAP:
    - contact = 0 for GAP_CYCLES cycles, then go to IDLE.
    - If GAP_CYCLES = 0, go to IDLE the next cycle.
- Row output, registered, one-cycle latency from columnas:
  - filas[r] <= 0 iff contact && r == key_row && columnas[key_col] == 0; otherwise 1.
  - Non-one-hot columnas: the rule is applied literally. All columns low with contact closed pulls the key's row low; all columns high gives filas = 1111.
  - Only one key is ever modelled; no ghosting or multi-key behaviour.
- The latched key and hold are constant from accept to return to IDLE; cmd_key changes during busy have no effect.
- Reset mid-operation: immediate return to reset values; a pending press is aborted and no release sequence is generated.
- Counter widths: bounce and gap counters are sized by $clog2 of their parameters (minimum 1 bit); the hold counter is 16 bits.

Test Plan:
Unless stated otherwise, use BOUNCE_CYCLES=8, BOUNCE_TOGGLE=2, GAP_CYCLES=4.
1. Reset: hold n_reset low with arbitrary columnas → filas=1111, contact=0, cmd_ready=1, busy=0; after release lfsr starts at 16'hACE1.
2. Clean press, BOUNCE_CYCLES=0:
   - Stimulus: cmd_key=4'b0110 (row 1, col 2), cmd_hold=5, columnas scanning one-hot low.
   - Required: filas=1101 exactly in cycles after columnas=1011, for 5 contact cycles.
   - Required: busy for 1+5+4 cycles, then cmd_ready=1.
3. Bounce: same key, cmd_hold=10, columnas fixed at 1011.
   - Required: filas[1] may toggle only on even counts within the 8-cycle press and release windows, matching a reference LFSR model.
   - Required: filas[1] stable 0 for 10 cycles; GAP of 4 cycles with filas=1111.
4. Handshake: assert cmd_valid with a second key while busy → not accepted and no effect; re-assert after cmd_ready=1 → accepted on the first ready cycle.
5. Column edge cases with contact closed on key 4'hF:
   - columnas=0000 → filas=0111.
   - columnas=1111 → filas=1111.
   - cmd_hold=0 → exactly 1 closed cycle.
6. Mid-operation reset: assert n_reset low during HOLD → filas=1111, contact=0, cmd_ready=1 asynchronously; the next command after release runs a full normal sequence.

Source files
------------

// File: rtl/keypad_emulator_if.sv
// Command handshake between a press requester (bench or self-test) and the keypad model.
interface keypad_emulator_if;
    logic        cmd_valid;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic        cmd_ready;
    logic        busy;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        input  cmd_ready,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        output cmd_ready,
        output busy
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model: answers column scans with row lines and models
// contact bounce on press and release for a single commanded key.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 2000,
    parameter int unsigned BOUNCE_TOGGLE = 50,
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [3:0]       columnas,
    keypad_emulator_if.slave cmd,
    output logic [3:0]       filas,
    output logic             contact
);

    localparam int unsigned BW     = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int unsigned TW     = (BOUNCE_TOGGLE > 1) ? $clog2(BOUNCE_TOGGLE) : 1;
    localparam int unsigned GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned B_LAST = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
    localparam int unsigned T_LAST = (BOUNCE_TOGGLE > 0) ? BOUNCE_TOGGLE - 1 : 0;
    localparam int unsigned G_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BPRESS   = 3'd1;
    localparam logic [2:0] S_HOLD     = 3'd2;
    localparam logic [2:0] S_BRELEASE = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    logic [2:0]    r_state;
    logic [15:0]   r_lfsr;
    logic [BW-1:0] r_bcnt;
    logic [TW-1:0] r_tcnt;
    logic [15:0]   r_hcnt;
    logic [GW-1:0] r_gcnt;
    logic [3:0]    r_key;
    logic [15:0]   r_hold;
    logic          r_contact;
    logic [3:0]    r_filas;
    logic          r_ready;
    logic          r_busy;

    logic [2:0]    w_state_n;
    logic [15:0]   w_lfsr_n;
    logic [BW-1:0] w_bcnt_n;
    logic [TW-1:0] w_tcnt_n;
    logic [15:0]   w_hcnt_n;
    logic [GW-1:0] w_gcnt_n;
    logic [3:0]    w_key_n;
    logic [15:0]   w_hold_n;
    logic          w_contact_n;
    logic [3:0]    w_filas_n;

    // Free-running Galois LFSR supplying the bounce randomness.
    always_comb begin
        w_lfsr_n = r_lfsr >> 1;
        if (r_lfsr[0]) begin
            w_lfsr_n = (r_lfsr >> 1) ^ LFSR_MASK;
        end
    end

    // Press sequencer: next state, counters, latched command and contact level.
    // A clean (no-bounce) press closes one cycle after entering HOLD, so HOLD
    // counts only cycles with the contact already closed.
    always_comb begin
        w_state_n   = r_state;
        w_bcnt_n    = r_bcnt;
        w_tcnt_n    = r_tcnt;
        w_hcnt_n    = r_hcnt;
        w_gcnt_n    = r_gcnt;
        w_key_n     = r_key;
        w_hold_n    = r_hold;
        w_contact_n = r_contact;
        case (r_state)
            S_IDLE: begin
                w_contact_n = 1'b0;
                if (cmd.cmd_valid && r_ready) begin
                    w_key_n   = cmd.cmd_key;
                    w_hold_n  = (cmd.cmd_hold == 16'd0) ? 16'd1 : cmd.cmd_hold;
                    w_bcnt_n  = '0;
                    w_tcnt_n  = '0;
                    w_hcnt_n  = '0;
                    w_gcnt_n  = '0;
                    w_state_n = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BPRESS;
                end
            end
            S_BPRESS, S_BRELEASE: begin
                if (r_tcnt == '0) begin
                    w_contact_n = r_lfsr[0];
                end
                w_tcnt_n = (r_tcnt == TW'(T_LAST)) ? '0 : r_tcnt + TW'(1);
                if (r_bcnt == BW'(B_LAST)) begin
                    w_contact_n = (r_state == S_BPRESS);
                    w_hcnt_n    = '0;
                    w_gcnt_n    = '0;
                    w_state_n   = (r_state == S_BPRESS) ? S_HOLD : S_GAP;
                end else begin
                    w_bcnt_n = r_bcnt + BW'(1);
                end
            end
            S_HOLD: begin
                w_contact_n = 1'b1;
                if (r_contact) begin
                    if (r_hcnt == r_hold - 16'd1) begin
                        w_bcnt_n = '0;
                        w_tcnt_n = '0;
                        w_gcnt_n = '0;
                        if (BOUNCE_CYCLES == 0) begin
                            w_contact_n = 1'b0;
                            w_state_n   = S_GAP;
                        end else begin
                            w_state_n = S_BRELEASE;
                        end
                    end else begin
                        w_hcnt_n = r_hcnt + 16'd1;
                    end
                end
            end
            S_GAP: begin
                w_contact_n = 1'b0;
                if (GAP_CYCLES == 0 || r_gcnt == GW'(G_LAST)) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_gcnt_n = r_gcnt + GW'(1);
                end
            end
            default: begin
                w_state_n   = S_IDLE;
                w_contact_n = 1'b0;
            end
        endcase
    end

    // Row response: pull the key's row low when closed and its column is driven.
    always_comb begin
        w_filas_n = 4'b1111;
        if (r_contact && !columnas[r_key[1:0]]) begin
            w_filas_n[r_key[3:2]] = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_bcnt    <= '0;
            r_tcnt    <= '0;
            r_hcnt    <= '0;
            r_gcnt    <= '0;
            r_key     <= '0;
            r_hold    <= '0;
            r_contact <= 1'b0;
            r_filas   <= 4'b1111;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lfsr    <= w_lfsr_n;
            r_bcnt    <= w_bcnt_n;
            r_tcnt    <= w_tcnt_n;
            r_hcnt    <= w_hcnt_n;
            r_gcnt    <= w_gcnt_n;
            r_key     <= w_key_n;
            r_hold    <= w_hold_n;
            r_contact <= w_contact_n;
            r_filas   <= w_filas_n;
            r_ready   <= (w_state_n == S_IDLE);
            r_busy    <= (w_state_n != S_IDLE);
        end
    end

    assign filas         = r_filas;
    assign contact       = r_contact;
    assign cmd.cmd_ready = r_ready;
    assign cmd.busy      = r_busy;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a clean-edge instance and a bouncing instance,
// both compared cycle by cycle against a waveform model built from the press rules.
module tb_keypad_emulator;

    localparam int B1   = 8;
    localparam int T    = 2;
    localparam int G    = 4;
    localparam int TABN = 2048;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] columnas = 4'b1111;
    logic [3:0] filas0, filas1;
    logic       contact0, contact1;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    logic [15:0] lfsr_tab [0:TABN-1];

    keypad_emulator_if if0 ();
    keypad_emulator_if if1 ();

    keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G), .LFSR_SEED(16'hACE1)) dut0 (
        .clk(clk), .n_reset(n_reset), .columnas(columnas), .cmd(if0), .filas(filas0), .contact(contact0)
    );

    keypad_emulator #(.BOUNCE_CYCLES(B1), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .n_reset(n_reset), .columnas(columnas), .cmd(if1), .filas(filas1), .contact(contact1)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the bench LFSR table is indexed by this.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Expected contact level in the j-th cycle after an accept at cycle a.
    function automatic logic exp_contact(input int j, input int b, input int h, input int a);
        int r;
        if (b == 0) return (j >= 1 && j <= h);
        if (j < b) return (j == 0) ? 1'b0 : lfsr_tab[a + 1 + ((j - 1) / T) * T][0];
        if (j < b + h) return 1'b1;
        if (j < 2 * b + h) begin
            r = j - b - h;
            return (r == 0) ? 1'b1 : lfsr_tab[a + 1 + b + h + ((r - 1) / T) * T][0];
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_cmd(input bit sel, input logic v, input logic [3:0] k, input logic [15:0] h);
        if (sel) begin
            if1.cmd_valid = v; if1.cmd_key = k; if1.cmd_hold = h;
        end else begin
            if0.cmd_valid = v; if0.cmd_key = k; if0.cmd_hold = h;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_filas0"},   16'(filas0),         16'hF);
        chk({tag, "_contact0"}, 16'(contact0),       16'h0);
        chk({tag, "_ready0"},   16'(if0.cmd_ready),  16'h1);
        chk({tag, "_busy0"},    16'(if0.busy),       16'h0);
        chk({tag, "_filas1"},   16'(filas1),         16'hF);
        chk({tag, "_contact1"}, 16'(contact1),       16'h0);
        chk({tag, "_ready1"},   16'(if1.cmd_ready),  16'h1);
        chk({tag, "_busy1"},    16'(if1.busy),       16'h0);
    endtask

    // One press, entered and left at a falling edge. col_mode: 0 scan, 1 fixed, 2 random.
    task automatic run_press(input bit sel, input logic [3:0] key, input logic [15:0] hold,
                             input int col_mode, input logic [3:0] col_fix,
                             input int intrude_at, input logic [3:0] key2, input logic [15:0] hold2,
                             input int abort_at);
        int a, b, h, busy_len, closed;
        logic [3:0] prev_col, col, one, exp_f, o_f;
        logic exp_c, prev_exp_c, o_c, o_r, o_b;
        logic [15:0] o_l;
        a = cyc;
        b = sel ? B1 : 0;
        h = (hold == 16'd0) ? 1 : int'(hold);
        busy_len = (b == 0) ? 1 + h + G : 2 * b + h + G;
        chk("accept_ready", 16'(sel ? if1.cmd_ready : if0.cmd_ready), 16'h1);
        drive_cmd(sel, 1'b1, key, hold);
        prev_col = columnas;
        prev_exp_c = 1'b0;
        closed = 0;
        for (int j = 0; j <= busy_len; j++) begin
            @(negedge clk);
            if (j == 0) drive_cmd(sel, 1'b0, key, hold);
            exp_c = exp_contact(j, b, h, a);
            exp_f = 4'b1111;
            if (prev_exp_c && !prev_col[key[1:0]]) exp_f[key[3:2]] = 1'b0;
            o_f = sel ? filas1 : filas0;
            o_c = sel ? contact1 : contact0;
            o_r = sel ? if1.cmd_ready : if0.cmd_ready;
            o_b = sel ? if1.busy : if0.busy;
            o_l = sel ? dut1.r_lfsr : dut0.r_lfsr;
            chk("contact", 16'(o_c), 16'(exp_c));
            chk("filas",   16'(o_f), 16'(exp_f));
            chk("busy",    16'(o_b), 16'(j < busy_len));
            chk("ready",   16'(o_r), 16'(j >= busy_len));
            chk("lfsr",    o_l, lfsr_tab[cyc]);
            if (o_c) closed++;
            if (j == abort_at) return;
            if (j == intrude_at) drive_cmd(sel, 1'b1, key2, hold2);
            one = 4'b0001 << (j % 4);
            case (col_mode)
                0:       col = ~one;
                1:       col = col_fix;
                default: col = 4'($urandom);
            endcase
            columnas = col;
            prev_col = col;
            prev_exp_c = exp_c;
        end
        if (b == 0) chk("closed_cycles", 16'(closed), 16'(h));
    endtask

    initial begin
        lfsr_tab[0] = 16'hACE1;
        for (int i = 1; i < TABN; i++) lfsr_tab[i] = lfsr_step(lfsr_tab[i - 1]);
        drive_cmd(1'b0, 1'b0, 4'h0, 16'h0);
        drive_cmd(1'b1, 1'b0, 4'h0, 16'h0);

        // Reset held with arbitrary columns.
        n_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            columnas = 4'($urandom);
            @(negedge clk);
        end
        chk_reset_vals("reset");
        chk("reset_lfsr", dut1.r_lfsr, 16'hACE1);
        n_reset = 1'b1;
        #1;
        chk("release_lfsr", dut1.r_lfsr, 16'hACE1);
        @(negedge clk);

        // Clean press, scanning columns.
        run_press(1'b0, 4'b0110, 16'd5, 0, 4'hF, -1, 4'h0, 16'h0, -1);
        // Bouncing press on a fixed column.
        run_press(1'b1, 4'b0110, 16'd10, 1, 4'b1011, -1, 4'h0, 16'h0, -1);
        // Command issued while busy is ignored, then taken on the first ready cycle.
        run_press(1'b1, 4'b0110, 16'd3, 1, 4'b1011, 5, 4'h9, 16'd2, -1);
        run_press(1'b1, 4'h9, 16'd2, 0, 4'hF, -1, 4'h0, 16'h0, -1);
        run_press(1'b0, 4'b0110, 16'd2, 1, 4'b1011, 3, 4'hC, 16'd4, -1);
        run_press(1'b0, 4'hC, 16'd4, 0, 4'hF, -1, 4'h0, 16'h0, -1);
        // Column edge cases and zero hold on key F.
        run_press(1'b0, 4'hF, 16'd3, 1, 4'b0000, -1, 4'h0, 16'h0, -1);
        run_press(1'b0, 4'hF, 16'd3, 1, 4'b1111, -1, 4'h0, 16'h0, -1);
        run_press(1'b0, 4'hF, 16'd0, 1, 4'b0000, -1, 4'h0, 16'h0, -1);
        run_press(1'b1, 4'hF, 16'd0, 1, 4'b0000, -1, 4'h0, 16'h0, -1);

        // Randomized presses on both instances.
        for (int i = 0; i < 12; i++) begin
            run_press(1'($urandom), 4'($urandom), 16'($urandom_range(12, 0)), 2, 4'hF, -1, 4'h0, 16'h0, -1);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // Reset during HOLD aborts the press; the next one runs normally.
        run_press(1'b1, 4'h5, 16'd6, 1, 4'b1101, -1, 4'h0, 16'h0, B1 + 2);
        #2 n_reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        drive_cmd(1'b1, 1'b0, 4'h0, 16'h0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        run_press(1'b1, 4'h5, 16'd6, 1, 4'b1101, -1, 4'h0, 16'h0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
